// File: rtl/mmio_switch_led_port.sv
// Switch/LED MMIO responder: synchronized, debounced switches with sticky change flags.
// Optional SWITCH_IRQ_EN adds a MASK register and a masked change interrupt.
module mmio_switch_led_port #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_7F00,
    parameter int          N_SW            = 10,
    parameter int          DEBOUNCE_CYCLES = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemWrite,
    input  logic [31:0]     DataAdr,
    input  logic [31:0]     WriteData,
    output logic [31:0]     ReadData,
    output logic            hit,
    input  logic [N_SW-1:0] switches,
`ifdef SWITCH_IRQ_EN
    output logic [N_SW-1:0] leds,
    output logic            irq
`else
    output logic [N_SW-1:0] leds
`endif
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] OFF_LED  = 3'd0;
    localparam logic [2:0] OFF_SW   = 3'd1;
    localparam logic [2:0] OFF_CHG  = 3'd2;
    localparam logic [2:0] OFF_RAW  = 3'd3;
    localparam logic [2:0] OFF_MASK = 3'd4;

    logic [N_SW-1:0] led_q;
    logic [N_SW-1:0] sync1_q;
    logic [N_SW-1:0] sync2_q;
    logic [N_SW-1:0] cand_q;
    logic [N_SW-1:0] deb_q;
    logic [N_SW-1:0] chg_q;
    logic [CW-1:0]   cnt_q;

    logic [2:0]      off;
    logic            wr_en;
    logic [N_SW-1:0] wdat;
    logic            deb_upd;
    logic [N_SW-1:0] chg_set;
    logic [N_SW-1:0] chg_clr;
    logic            unused_bits;

    assign hit         = DataAdr[31:5] == BASE_ADDR[31:5];
    assign off         = DataAdr[4:2];
    assign wr_en       = MemWrite && hit;
    assign wdat        = WriteData[N_SW-1:0];
    assign unused_bits = ^{DataAdr[1:0], WriteData};

    assign deb_upd = (sync2_q == cand_q) && (cnt_q == CNT_MAX);
    assign chg_set = deb_upd ? (deb_q ^ cand_q) : '0;
    assign chg_clr = (wr_en && off == OFF_CHG) ? wdat : '0;

    // One counter serves the whole vector: any bit moving restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= switches;
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= '0;
            end else if (cnt_q == CNT_MAX) begin
                deb_q <= cand_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q <= '0;
        end else if (wr_en && off == OFF_LED) begin
            led_q <= wdat;
        end
    end

    // A new change on the same edge as a W1C wins over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chg_q <= '0;
        end else begin
            chg_q <= (chg_q & ~chg_clr) | chg_set;
        end
    end

`ifdef SWITCH_IRQ_EN
    logic [N_SW-1:0] mask_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
        end else if (wr_en && off == OFF_MASK) begin
            mask_q <= wdat;
        end
    end

    assign irq = |(chg_q & mask_q);
`endif

    always_comb begin
        ReadData = 32'h0;
        if (hit) begin
            case (off)
                OFF_LED:  ReadData = 32'(led_q);
                OFF_SW:   ReadData = 32'(deb_q);
                OFF_CHG:  ReadData = 32'(chg_q);
                OFF_RAW:  ReadData = 32'(sync2_q);
`ifdef SWITCH_IRQ_EN
                OFF_MASK: ReadData = 32'(mask_q);
`endif
                default:  ReadData = 32'h0;
            endcase
        end
    end

    assign leds = led_q;

endmodule

// File: tb/tb_mmio_switch_led_port.sv
// Scoreboard bench for mmio_switch_led_port: expected register reads are
// queued as stimulus is applied and drained against the bus each cycle.
module tb_mmio_switch_led_port;

    localparam logic [31:0] A_LED  = 32'h0000_7F00;
    localparam logic [31:0] A_SW   = 32'h0000_7F04;
    localparam logic [31:0] A_CHG  = 32'h0000_7F08;
    localparam logic [31:0] A_RAW  = 32'h0000_7F0C;
    localparam logic [31:0] A_MASK = 32'h0000_7F10;
    localparam logic [31:0] A_RSV  = 32'h0000_7F1C;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        hit;
    logic [9:0]  switches;
    logic [9:0]  leds;
`ifdef SWITCH_IRQ_EN
    logic        irq;
`endif

    mmio_switch_led_port dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .hit       (hit),
        .switches  (switches),
`ifdef SWITCH_IRQ_EN
        .leds      (leds),
        .irq       (irq)
`else
        .leds      (leds)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] adr;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] adr,
                        input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.adr = adr;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            MemWrite = 1'b0;
            DataAdr  = e.adr;
            #1;
            chk(e.tag, ReadData, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
        switches  = 10'h3FF;

        repeat (3) tick();
        chk("rst_leds", 32'(leds), 32'h0);
        push("rst_led", A_LED, 32'h0);
        push("rst_sw", A_SW, 32'h0);
        push("rst_chg", A_CHG, 32'h0);
        drain();
        for (int k = 0; k < 10; k++) begin
            tick();
            push("rst_sw_hold", A_SW, 32'h0);
            drain();
        end

        switches = 10'h0;
        reset    = 1'b1;
        repeat (4) tick();

        // Five-cycle pulse must never reach SW or CHG.
        switches = 10'd4;
        for (int k = 1; k <= 20; k++) begin
            tick();
            push("glitch_raw", A_RAW, (k >= 2 && k <= 6) ? 32'd4 : 32'd0);
            push("glitch_sw", A_SW, 32'h0);
            push("glitch_chg", A_CHG, 32'h0);
            drain();
            if (k == 5) switches = 10'h0;
        end

        // Step: SW follows exactly 11 edges later.
        switches = 10'd4;
        for (int k = 1; k <= 11; k++) begin
            tick();
            push("lat_raw", A_RAW, (k >= 2) ? 32'd4 : 32'd0);
            push("lat_sw", A_SW, (k == 11) ? 32'd4 : 32'd0);
            push("lat_chg", A_CHG, (k == 11) ? 32'd4 : 32'd0);
            drain();
        end

        wr(A_LED, 32'hFFFF_F2A5);
        chk("led_pins", 32'(leds), 32'h2A5);
        push("led_rd", A_LED, 32'h2A5);
        push("led_rd_byte", 32'h0000_7F03, 32'h2A5);
        drain();
        DataAdr = 32'h0000_8000;
        #1;
        chk("miss_hit", 32'(hit), 32'h0);
        chk("miss_rd", ReadData, 32'h0);
        wr(32'h0000_8000, 32'hFFFF_F0F0);
        chk("miss_leds", 32'(leds), 32'h2A5);
        wr(A_SW, 32'h0);
        wr(A_RSV, 32'hFFFF_FFFF);
        push("ro_sw", A_SW, 32'd4);
        push("rsv_rd", A_RSV, 32'h0);
        push("led_keep", A_LED, 32'h2A5);
        drain();

        // Clear of bit 2 lands on the edge bit 2 changes again.
        switches = 10'd0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            push("race_sw", A_SW, 32'd4);
            drain();
        end
        MemWrite  = 1'b1;
        DataAdr   = A_CHG;
        WriteData = 32'd4;
        tick();
        MemWrite  = 1'b0;
        push("race_chg", A_CHG, 32'd4);
        push("race_sw_new", A_SW, 32'd0);
        drain();
        wr(A_CHG, 32'd4);
        push("w1c_chg", A_CHG, 32'd0);
        drain();

`ifdef SWITCH_IRQ_EN
        wr(A_MASK, 32'd4);
        push("mask_rd", A_MASK, 32'd4);
        drain();
        switches = 10'd4;
        repeat (11) tick();
        chk("irq_set", 32'(irq), 32'h1);
        wr(A_CHG, 32'd4);
        chk("irq_clr", 32'(irq), 32'h0);
        wr(A_MASK, 32'd0);
        switches = 10'd12;
        repeat (11) tick();
        chk("irq_masked", 32'(irq), 32'h0);
        push("irq_chg", A_CHG, 32'd8);
        drain();
`else
        wr(A_MASK, 32'd4);
        push("mask_absent", A_MASK, 32'h0);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
